// File: rtl/adc_interface_if.sv
// ---------------------------------------------------------------------------
// adc_interface_if
// Groups the serial ADC pins and the parallel result bus of adc_interface.
//
// Members:
//   miso     serial data from the ADC (driven by the ADC / bench)
//   cs_n     ADC chip select, active-low
//   data_o   last completed conversion word, DATA_W bits
//   valid_o  one-cycle strobe marking an update of data_o / error_o
//   error_o  null bit of the last completed frame was 1
//
// Modports:
//   master   the read master (adc_interface): samples miso, drives the rest
//   slave    the ADC side / consumer: drives miso, observes the rest
// ---------------------------------------------------------------------------
interface adc_interface_if #(
  parameter int DATA_W = 12
);
  logic              miso;
  logic              cs_n;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              error_o;

  modport master (
    input  miso,
    output cs_n,
    output data_o,
    output valid_o,
    output error_o
  );

  modport slave (
    output miso,
    input  cs_n,
    input  data_o,
    input  valid_o,
    input  error_o
  );
endinterface

// File: rtl/adc_interface.sv
// ---------------------------------------------------------------------------
// adc_interface
// Free-running SPI-style read master for a serial ADC. Runs on the serial
// clock sck itself: every rising edge is one bit time. A frame is
// CS_HIGH_CYCLES edges with cs_n high, one leading null bit, then DATA_W data
// bits MSB first. The finished word is published on data_o together with a
// one-cycle valid_o strobe; error_o reports a null bit that read back as 1.
//
// Ports:
//   sck   input   serial clock, also the system clock (rising edge)
//   rst   input   synchronous active-high reset
//   bus   adc_interface_if.master  (miso in; cs_n, data_o, valid_o, error_o out)
//
// Parameters:
//   DATA_W          data bits per frame (>= 3)
//   CS_HIGH_CYCLES  sck cycles cs_n stays high between frames (>= 1)
//
// Build option:
//   ADC_ERROR_STICKY_EN  when defined, error_o is sticky: once a frame with a
//                        bad null bit is seen it stays 1 until rst. When not
//                        defined, error_o follows the most recent frame.
//
// miso is sampled directly without a synchroniser; the ADC launches it on the
// falling edge of the shared sck, so it is stable at our rising edge.
// ---------------------------------------------------------------------------
module adc_interface #(
  parameter int DATA_W         = 12,
  parameter int CS_HIGH_CYCLES = 2
) (
  input  logic            sck,
  input  logic            rst,
  adc_interface_if.master bus
);

  // Idle counter only needs to reach CS_HIGH_CYCLES-1.
  localparam int IDLE_CNT_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam int BIT_CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t                state_r;
  logic [IDLE_CNT_W-1:0] idle_cnt_r;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  // The last data bit is taken straight from miso, so only DATA_W-1 bits
  // need to be held here.
  logic [DATA_W-2:0]     shift_r;
  logic                  null_r;
  logic                  cs_n_r;
  logic [DATA_W-1:0]     data_r;
  logic                  valid_r;
  logic                  error_r;

  // Frame sequencer: chip select, bit sampling and result publication.
  always_ff @(posedge sck) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idle_cnt_r <= IDLE_CNT_W'(0);
      bit_cnt_r  <= BIT_CNT_W'(0);
      shift_r    <= (DATA_W-1)'(0);
      null_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      data_r     <= DATA_W'(0);
      valid_r    <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      // Strobe defaults low; only the final-bit edge raises it.
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (idle_cnt_r == IDLE_CNT_W'(CS_HIGH_CYCLES - 1)) begin
            cs_n_r     <= 1'b0;
            idle_cnt_r <= IDLE_CNT_W'(0);
            state_r    <= ST_LEAD;
          end else begin
            cs_n_r     <= 1'b1;
            idle_cnt_r <= idle_cnt_r + IDLE_CNT_W'(1);
          end
        end

        ST_LEAD: begin
          // First edge with cs_n low carries the null bit.
          null_r    <= bus.miso;
          bit_cnt_r <= BIT_CNT_W'(DATA_W - 1);
          state_r   <= ST_SHIFT;
        end

        ST_SHIFT: begin
          shift_r <= {shift_r[DATA_W-3:0], bus.miso};
          if (bit_cnt_r == BIT_CNT_W'(0)) begin
            // Bit 0 goes straight into the result on the same edge.
            data_r     <= {shift_r, bus.miso};
`ifdef ADC_ERROR_STICKY_EN
            error_r    <= error_r | null_r;
`else
            error_r    <= null_r;
`endif
            valid_r    <= 1'b1;
            cs_n_r     <= 1'b1;
            idle_cnt_r <= IDLE_CNT_W'(0);
            state_r    <= ST_IDLE;
          end else begin
            bit_cnt_r  <= bit_cnt_r - BIT_CNT_W'(1);
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle.
          cs_n_r     <= 1'b1;
          idle_cnt_r <= IDLE_CNT_W'(0);
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cs_n    = cs_n_r;
  assign bus.data_o  = data_r;
  assign bus.valid_o = valid_r;
  assign bus.error_o = error_r;

endmodule

// File: tb/tb_adc_interface.sv
// ---------------------------------------------------------------------------
// tb_adc_interface
// Bench for adc_interface. A behavioural ADC drives miso on falling edges
// while cs_n is low and pushes the expected {error, data} of each frame into a
// scoreboard queue as the frame starts; a monitor on the falling edge pops and
// compares on every valid_o, and checks frame timing and reset behaviour.
// ---------------------------------------------------------------------------
module tb_adc_interface;

  localparam int DATA_W = 12;
  localparam int CSH    = 2;
  localparam int NF     = 8;

  logic sck;
  logic rst;

  adc_interface_if #(.DATA_W(DATA_W)) bus ();

  adc_interface #(
    .DATA_W         (DATA_W),
    .CS_HIGH_CYCLES (CSH)
  ) dut (
    .sck (sck),
    .rst (rst),
    .bus (bus)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  // Frame stimulus: null bit and data word. Frame 4 is cut short by reset.
  logic [NF-1:0]     fr_null = 8'b0010_0001;
  logic [DATA_W-1:0] fr_data [NF] = '{12'h48F, 12'hA5C, 12'hFFF, 12'h000,
                                      12'h3C3, 12'hFFF, 12'h123, 12'h5A5};

  logic [DATA_W:0] exp_q[$];
  logic            sticky_acc = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Rising-edge count and the reset value the DUT saw on that edge.
  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge sck) begin
    cyc++;
    rst_at_edge = rst;
  end

  // Behavioural ADC: null bit then data MSB first, launched on falling edges.
  int              fi = 0;
  int              adc_pos = 0;
  logic            cur_null;
  logic [DATA_W-1:0] cur_data;
  always @(negedge sck) begin
    if (bus.cs_n !== 1'b0) begin
      adc_pos  = 0;
      bus.miso = 1'b0;
    end else if (adc_pos == 0) begin
      cur_null = (fi < NF) ? fr_null[fi] : 1'b0;
      cur_data = (fi < NF) ? fr_data[fi] : 12'h000;
      fi++;
`ifdef ADC_ERROR_STICKY_EN
      sticky_acc = sticky_acc | cur_null;
      exp_q.push_back({sticky_acc, cur_data});
`else
      exp_q.push_back({cur_null, cur_data});
`endif
      bus.miso = cur_null;
      adc_pos  = 1;
    end else if (adc_pos <= DATA_W) begin
      bus.miso = cur_data[DATA_W - adc_pos];
      adc_pos++;
    end else begin
      bus.miso = 1'b0;
    end
  end

  // Output monitor, sampled mid-cycle.
  int              n_valid = 0;
  int              hi_cnt = 0;
  int              fall_cyc = -1;
  int              last_valid_cyc = -1;
  logic            prev_cs_n = 1'b1;
  logic            prev_valid = 1'b0;
  logic [DATA_W-1:0] last_data = 12'h000;
  logic            last_err = 1'b0;
  logic [DATA_W:0] exp_v;
  always @(negedge sck) begin
    if (cyc > 0) begin
      if (rst_at_edge) begin
        check_eq("rst_cs_n",  {31'd0, bus.cs_n},    32'd1);
        check_eq("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        check_eq("rst_data",  {20'd0, bus.data_o},  32'd0);
        check_eq("rst_error", {31'd0, bus.error_o}, 32'd0);
        hi_cnt = 1; fall_cyc = -1; last_valid_cyc = -1;
        last_data = 12'h000; last_err = 1'b0;
      end else begin
        if (bus.cs_n === 1'b1) begin
          hi_cnt++;
        end else if (prev_cs_n === 1'b1) begin
          check_eq("cs_high_len", hi_cnt, CSH);
          fall_cyc = cyc;
          hi_cnt   = 0;
        end
        if (prev_valid) check_eq("valid_width", {31'd0, bus.valid_o}, 32'd0);
        if (bus.valid_o === 1'b1) begin
          n_valid++;
          check_eq("cs_n_at_valid", {31'd0, bus.cs_n}, 32'd1);
          check_eq("valid_latency", cyc - fall_cyc, DATA_W + 1);
          if (last_valid_cyc >= 0)
            check_eq("valid_period", cyc - last_valid_cyc, CSH + DATA_W + 1);
          last_valid_cyc = cyc;
          if (exp_q.size() == 0) begin
            check_eq("sb_nonempty", 32'd0, 32'd1);
          end else begin
            exp_v = exp_q.pop_front();
            check_eq("data",  {20'd0, bus.data_o},  {20'd0, exp_v[DATA_W-1:0]});
            check_eq("error", {31'd0, bus.error_o}, {31'd0, exp_v[DATA_W]});
          end
          last_data = bus.data_o;
          last_err  = bus.error_o;
        end else begin
          check_eq("data_hold",  {20'd0, bus.data_o},  {20'd0, last_data});
          check_eq("error_hold", {31'd0, bus.error_o}, {31'd0, last_err});
        end
      end
      prev_cs_n  = bus.cs_n;
      prev_valid = bus.valid_o;
    end
  end

  task automatic wait_valids(input int target, input string tag);
    for (int i = 0; i < 400 && n_valid < target; i++) @(negedge sck);
    check_eq(tag, {31'd0, n_valid >= target}, 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    bus.miso = 1'b0;
    repeat (4) @(negedge sck);
    #1 rst = 1'b0;

    // Frames 0..3: error frame, clean frame, back-to-back 0xFFF / 0x000.
    wait_valids(4, "timeout_phase1");

    // Frame 4: reset after the null bit plus six data bits.
    for (int i = 0; i < 50 && bus.cs_n !== 1'b0; i++) @(negedge sck);
    check_eq("cs_fall_seen", {31'd0, bus.cs_n}, 32'd0);
    repeat (7) @(negedge sck);
    #1;
    rst = 1'b1;
    exp_q.delete();
    sticky_acc = 1'b0;
    repeat (2) @(negedge sck);
    #1 rst = 1'b0;

    // Frames 5..7: miso stuck high, then two clean frames.
    wait_valids(n_valid + 3, "timeout_phase2");
    repeat (3) @(negedge sck);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
